wash_phase_timer: RTL and testbench
===================================

// Module: wash_phase_timer
// PURPOSE
//  Timebase for the wash controller (auto_machine): times the agitate (cycle) and spin phases.
//  The controller raises cycle_en/spin_en while in the matching state. This block drives the
//  controller's cycle_timeout/spin_timeout inputs.
//  Durations are runtime-programmable in ticks from a clock prescaler.
//  remaining is exported for a front-panel display.
// PARAMETERS
//  TICK_DIV     100   clocks per tick (>=1; 1 = one tick per clock)
//  CNT_W        16    width of duration registers and down-counter
//  CYCLE_TICKS  600   reset value of cycle duration register
//  SPIN_TICKS   300   reset value of spin duration register
// PORTS
//  clk            in   1      system clock
//  reset          in   1      asynchronous, active-high
//  cycle_en       in   1      level; high = controller in cycle phase
//  spin_en        in   1      level; high = controller in spin phase
//  pause          in   1      level; freezes prescaler and counter (door/lid event)
//  cfg_we         in   1      write strobe for duration registers
//  cfg_sel        in   1      0 = cycle duration, 1 = spin duration
//  cfg_data       in   CNT_W  duration in ticks
//  cycle_timeout  out  1      high from cycle expiry until cycle_en drops
//  spin_timeout   out  1      high from spin expiry until spin_en drops
//  busy           out  1      high while counting (RUN_C/RUN_S), including while paused
//  remaining      out  CNT_W  ticks left in the active phase; 0 otherwise
//  tick           out  1      one-clock strobe per prescaler rollover while counting
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, prescaler 0, dur_c=CYCLE_TICKS, dur_s=SPIN_TICKS.
//  All outputs are registered. States: IDLE, RUN_C, RUN_S, EXP_C, EXP_S.
//  IDLE:
//   - cycle_en=1 -> RUN_C; remaining<=dur_c; prescaler<=0.
//   - else spin_en=1 -> RUN_S; remaining<=dur_s.
//   - Both high -> cycle wins.
//  RUN_x, pause=0:
//   - Prescaler counts 0..TICK_DIV-1; at TICK_DIV-1: tick=1, remaining-=1, prescaler wraps to 0.
//   - On the edge remaining goes 1->0: state EXP_x; x_timeout<=1; busy<=0.
//   - Latency: timeout rises exactly TICK_DIV*N clocks after the RUN entry edge (N = loaded duration).
//  RUN_x, pause=1: prescaler and remaining hold; tick=0; busy stays 1. Pause has no effect in IDLE/EXP.
//  Zero duration: N=0 loaded -> EXP_x on the next clock (timeout 1 clock after entry).
//  Abort: enable drops in RUN_x -> IDLE; remaining<=0; no timeout is produced.
//  EXP_x: timeout held high until the enable drops -> IDLE with the timeout cleared on that edge.
//   The other enable is ignored until IDLE is re-entered.
//  Back-to-back phase: spin_en high in the same clock cycle_en drops from EXP_C -> IDLE first, then RUN_S.
//   This costs a 1-clock restart gap.
//  cfg writes: accepted in any state; affect only the next load, never a running count.
//  Reset mid-run: immediate return to IDLE; duration registers revert to defaults.
//  remaining never wraps below 0; the counter only decrements while remaining>0.
// STRUCTURE
//  wash_pkg (shared): state encoding localparams, CFG_SEL_CYCLE=0 / CFG_SEL_SPIN=1.
//  Sub-module tick_prescaler:
//   - params TICK_DIV; ports clk, reset, run (=busy & ~pause), clr, tick.
//   - clr zeroes the count on a phase load.
//  Top: FSM, duration registers and down-counter, in one file with the prescaler instance.
// TESTING
//  1 Cycle expiry, TICK_DIV=4, dur_c=3:
//    cycle_en high at t0 -> busy=1, remaining 3,2,1,0 stepping every 4 clocks;
//    cycle_timeout=1 at t0+12; holds until cycle_en=0, then 0 next edge.
//  2 Pause: dur_s=5, pause for 10 clocks mid-phase -> spin_timeout at 20+10 = 30 clocks;
//    remaining frozen and tick=0 throughout the pause.
//  3 Abort: cycle_en dropped at remaining=2 -> IDLE, remaining=0, cycle_timeout never asserts;
//    a restart reloads the full dur_c.
//  4 Config: write cfg_sel=1, data=2 during RUN_C -> current cycle unaffected;
//    the following spin expires after 8 clocks (TICK_DIV=4).
//  5 Priority/zero: cycle_en and spin_en high together -> RUN_C only;
//    dur_c=0 -> cycle_timeout exactly 1 clock after entry.
//  6 Async reset asserted mid-RUN_S -> all outputs 0 immediately;
//    dur_c/dur_s read back CYCLE_TICKS/SPIN_TICKS via full-length runs.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared definitions for the wash controller timebase: phase state encoding
// and the duration-register select codes.
package wash_pkg;

    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_RUN_C = 3'd1;
    localparam logic [2:0] ENC_RUN_S = 3'd2;
    localparam logic [2:0] ENC_EXP_C = 3'd3;
    localparam logic [2:0] ENC_EXP_S = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ENC_IDLE,
        ST_RUN_C = ENC_RUN_C,
        ST_RUN_S = ENC_RUN_S,
        ST_EXP_C = ENC_EXP_C,
        ST_EXP_S = ENC_EXP_S
    } phase_state_e;

    localparam logic CFG_SEL_CYCLE = 1'b0;
    localparam logic CFG_SEL_SPIN  = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Clock prescaler: counts 0..TICK_DIV-1 while run is high and flags the
// rollover cycle. clr restarts the count so a freshly loaded phase always
// gets a full first tick period.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] count;

    // Rollover strobe: combinational so the owner can act on the same edge.
    assign tick = run && (count == LAST);

    // Count register: cleared on load, frozen while not running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + PW'(1);
        end
    end

endmodule

// File: rtl/wash_phase_timer.sv
// Agitate/spin phase timer for the wash controller. Loads a programmable
// duration on phase entry, counts it down one step per prescaler tick and
// holds a timeout flag until the controller leaves the phase.
module wash_phase_timer
    import wash_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 100,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned CYCLE_TICKS = 600,
    parameter int unsigned SPIN_TICKS  = 300
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cycle_en,
    input  logic             spin_en,
    input  logic             pause,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             cycle_timeout,
    output logic             spin_timeout,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic             tick,
    output phase_state_e     state_dbg
);

    phase_state_e     state, state_nxt;
    logic [CNT_W-1:0] dur_c, dur_s;
    logic [CNT_W-1:0] rem_nxt;
    logic             busy_nxt, cto_nxt, sto_nxt, tick_nxt;
    logic             load, wrap, phase_en, is_cycle;

    assign state_dbg = state;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (busy & ~pause),
        .clr   (load),
        .tick  (wrap)
    );

    // Duration registers: writes only change what the next phase load picks up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dur_c <= CNT_W'(CYCLE_TICKS);
            dur_s <= CNT_W'(SPIN_TICKS);
        end else if (cfg_we) begin
            if (cfg_sel == CFG_SEL_SPIN) dur_s <= cfg_data;
            else                         dur_c <= cfg_data;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            remaining     <= '0;
            busy          <= 1'b0;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
            tick          <= 1'b0;
        end else begin
            state         <= state_nxt;
            remaining     <= rem_nxt;
            busy          <= busy_nxt;
            cycle_timeout <= cto_nxt;
            spin_timeout  <= sto_nxt;
            tick          <= tick_nxt;
        end
    end

    // Next-state, down-counter and output decode.
    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        busy_nxt  = busy;
        cto_nxt   = cycle_timeout;
        sto_nxt   = spin_timeout;
        tick_nxt  = 1'b0;
        load      = 1'b0;
        is_cycle  = (state == ST_RUN_C);
        phase_en  = is_cycle ? cycle_en : spin_en;

        case (state)
            ST_IDLE: begin
                rem_nxt  = '0;
                busy_nxt = 1'b0;
                cto_nxt  = 1'b0;
                sto_nxt  = 1'b0;
                // Cycle wins when both enables are high.
                if (cycle_en) begin
                    state_nxt = ST_RUN_C;
                    rem_nxt   = dur_c;
                    busy_nxt  = 1'b1;
                    load      = 1'b1;
                end else if (spin_en) begin
                    state_nxt = ST_RUN_S;
                    rem_nxt   = dur_s;
                    busy_nxt  = 1'b1;
                    load      = 1'b1;
                end
            end

            ST_RUN_C, ST_RUN_S: begin
                if (!phase_en) begin
                    // Abort: the controller left the phase early, no timeout.
                    state_nxt = ST_IDLE;
                    rem_nxt   = '0;
                    busy_nxt  = 1'b0;
                end else if ((remaining == '0) ||
                             (wrap && (remaining == CNT_W'(1)))) begin
                    // Expiry, either a zero-length load or the final tick.
                    state_nxt = is_cycle ? ST_EXP_C : ST_EXP_S;
                    rem_nxt   = '0;
                    busy_nxt  = 1'b0;
                    tick_nxt  = wrap;
                    if (is_cycle) cto_nxt = 1'b1;
                    else          sto_nxt = 1'b1;
                end else if (wrap) begin
                    tick_nxt = 1'b1;
                    rem_nxt  = remaining - CNT_W'(1);
                end
            end

            ST_EXP_C: begin
                if (!cycle_en) begin
                    state_nxt = ST_IDLE;
                    cto_nxt   = 1'b0;
                end
            end

            ST_EXP_S: begin
                if (!spin_en) begin
                    state_nxt = ST_IDLE;
                    sto_nxt   = 1'b0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                rem_nxt   = '0;
                busy_nxt  = 1'b0;
                cto_nxt   = 1'b0;
                sto_nxt   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer with a 4-clock tick and short default
// durations (cycle 6, spin 5). Inputs change and outputs are sampled 1 time
// unit after each rising edge.
module tb_wash_phase_timer;
    import wash_pkg::*;

    localparam int unsigned TD = 4;

    logic         clk, reset;
    logic         cycle_en, spin_en, pause, cfg_we, cfg_sel;
    logic [15:0]  cfg_data;
    logic         cycle_timeout, spin_timeout, busy, tick;
    logic [15:0]  remaining;
    phase_state_e state_dbg;

    int n_pass  = 0;
    int n_total = 0;

    wash_phase_timer #(
        .TICK_DIV    (TD),
        .CNT_W       (16),
        .CYCLE_TICKS (6),
        .SPIN_TICKS  (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cycle_en      (cycle_en),
        .spin_en       (spin_en),
        .pause         (pause),
        .cfg_we        (cfg_we),
        .cfg_sel       (cfg_sel),
        .cfg_data      (cfg_data),
        .cycle_timeout (cycle_timeout),
        .spin_timeout  (spin_timeout),
        .busy          (busy),
        .remaining     (remaining),
        .tick          (tick),
        .state_dbg     (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cfg_write(input logic sel, input logic [15:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cycle_en = 1'b0; spin_en = 1'b0; pause = 1'b0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_data = '0;
        cyc(2);
        chk("rst_busy", busy, 0);
        chk("rst_rem", remaining, 0);
        chk("rst_cto", cycle_timeout, 0);
        chk("rst_sto", spin_timeout, 0);
        chk("rst_tick", tick, 0);
        chk("rst_state", state_dbg, ST_IDLE);
        reset = 1'b0;
        cyc(1);

        // 1: cycle expiry, dur_c=3 -> timeout 12 clocks after entry
        cfg_write(CFG_SEL_CYCLE, 16'd3);
        cycle_en = 1'b1;
        cyc(1);
        chk("t1_busy", busy, 1);
        chk("t1_rem_e0", remaining, 3);
        chk("t1_state", state_dbg, ST_RUN_C);
        cyc(3);
        chk("t1_rem_e3", remaining, 3);
        chk("t1_tick_e3", tick, 0);
        cyc(1);
        chk("t1_rem_e4", remaining, 2);
        chk("t1_tick_e4", tick, 1);
        cyc(1);
        chk("t1_tick_e5", tick, 0);
        cyc(3);
        chk("t1_rem_e8", remaining, 1);
        cyc(3);
        chk("t1_cto_e11", cycle_timeout, 0);
        chk("t1_busy_e11", busy, 1);
        cyc(1);
        chk("t1_cto_e12", cycle_timeout, 1);
        chk("t1_busy_e12", busy, 0);
        chk("t1_rem_e12", remaining, 0);
        chk("t1_state_exp", state_dbg, ST_EXP_C);
        cyc(3);
        chk("t1_cto_hold", cycle_timeout, 1);
        cycle_en = 1'b0;
        cyc(1);
        chk("t1_cto_clr", cycle_timeout, 0);
        chk("t1_state_idle", state_dbg, ST_IDLE);

        // 2: spin with 10-clock pause -> timeout at 30 clocks
        cfg_write(CFG_SEL_SPIN, 16'd5);
        spin_en = 1'b1;
        cyc(1);
        chk("t2_rem_e0", remaining, 5);
        cyc(6);
        chk("t2_rem_e6", remaining, 4);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("t2_pause_tick", tick, 0);
            chk("t2_pause_rem", remaining, 4);
            chk("t2_pause_busy", busy, 1);
        end
        pause = 1'b0;
        cyc(2);
        chk("t2_rem_e18", remaining, 3);
        cyc(11);
        chk("t2_rem_e29", remaining, 1);
        chk("t2_sto_e29", spin_timeout, 0);
        cyc(1);
        chk("t2_sto_e30", spin_timeout, 1);
        spin_en = 1'b0;
        cyc(1);
        chk("t2_sto_clr", spin_timeout, 0);

        // 3: abort at remaining=2, then restart reloads full duration
        cycle_en = 1'b1;
        cyc(1);
        chk("t3_rem_e0", remaining, 3);
        cyc(4);
        chk("t3_rem_e4", remaining, 2);
        cycle_en = 1'b0;
        cyc(1);
        chk("t3_state", state_dbg, ST_IDLE);
        chk("t3_rem", remaining, 0);
        chk("t3_busy", busy, 0);
        cyc(12);
        chk("t3_no_cto", cycle_timeout, 0);
        cycle_en = 1'b1;
        cyc(1);
        chk("t3_reload", remaining, 3);
        cycle_en = 1'b0;
        cyc(1);

        // 4: cfg writes mid-run leave current count alone; back-to-back spin
        cycle_en = 1'b1;
        cyc(1);
        chk("t4_rem_e0", remaining, 3);
        cfg_write(CFG_SEL_SPIN, 16'd2);
        cfg_write(CFG_SEL_CYCLE, 16'd9);
        cyc(9);
        chk("t4_cto_e11", cycle_timeout, 0);
        cyc(1);
        chk("t4_cto_e12", cycle_timeout, 1);
        cycle_en = 1'b0; spin_en = 1'b1;
        cyc(1);
        chk("t4_gap_state", state_dbg, ST_IDLE);
        chk("t4_gap_cto", cycle_timeout, 0);
        cyc(1);
        chk("t4_spin_state", state_dbg, ST_RUN_S);
        chk("t4_spin_rem", remaining, 2);
        cyc(7);
        chk("t4_sto_e7", spin_timeout, 0);
        cyc(1);
        chk("t4_sto_e8", spin_timeout, 1);
        spin_en = 1'b0;
        cyc(1);

        // 5: priority and zero duration
        cycle_en = 1'b1; spin_en = 1'b1;
        cyc(1);
        chk("t5_prio_state", state_dbg, ST_RUN_C);
        chk("t5_prio_rem", remaining, 9);
        cycle_en = 1'b0; spin_en = 1'b0;
        cyc(1);
        cfg_write(CFG_SEL_CYCLE, 16'd0);
        cycle_en = 1'b1;
        cyc(1);
        chk("t5_zero_busy", busy, 1);
        chk("t5_zero_cto0", cycle_timeout, 0);
        cyc(1);
        chk("t5_zero_cto1", cycle_timeout, 1);
        chk("t5_zero_state", state_dbg, ST_EXP_C);
        spin_en = 1'b1;
        cyc(2);
        chk("t5_ign_state", state_dbg, ST_EXP_C);
        chk("t5_ign_sto", spin_timeout, 0);
        cycle_en = 1'b0; spin_en = 1'b0;
        cyc(1);

        // 6: async reset mid-spin, then defaults read back via full runs
        spin_en = 1'b1;
        cyc(3);
        chk("t6_pre_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rem", remaining, 0);
        chk("t6_rst_state", state_dbg, ST_IDLE);
        chk("t6_rst_tick", tick, 0);
        cyc(1);
        reset = 1'b0; spin_en = 1'b0;
        cycle_en = 1'b1;
        cyc(1);
        chk("t6_dur_c", remaining, 6);
        cyc(23);
        chk("t6_cto_e23", cycle_timeout, 0);
        cyc(1);
        chk("t6_cto_e24", cycle_timeout, 1);
        cycle_en = 1'b0;
        cyc(1);
        spin_en = 1'b1;
        cyc(1);
        chk("t6_dur_s", remaining, 5);
        cyc(19);
        chk("t6_sto_e19", spin_timeout, 0);
        cyc(1);
        chk("t6_sto_e20", spin_timeout, 1);
        spin_en = 1'b0;
        cyc(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
